// File: rtl/alu_one.sv
// ----------------------------------------------------------------------------
// alu_one: integer ALU for the single-cycle ARM datapath.
// Performs ADD, SUB, AND and ORR. Result and NZCV flags are combinational.
// A registered copy of the flags (FlagsQ) is loaded when FlagWrite is high
// and feeds the conditional-execution logic.
// Optional feature: define ALU_ONE_OVF_STICKY_EN to build a sticky overflow
// bit. Without it OvfSticky is tied low and no register exists for it.
// ----------------------------------------------------------------------------
module alu_one #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [1:0]       ALUControl,
    input  logic             FlagWrite,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags,
    output logic [3:0]       FlagsQ,
    output logic             OvfSticky
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_ORR = 2'b11
    } alu_op_e;

    localparam int MSB = WIDTH - 1;

    alu_op_e          op;
    logic [WIDTH-1:0] src_b_eff;
    logic [WIDTH:0]   sum;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic [3:0]       flags_d;
    logic [3:0]       flags_q;

    assign op = alu_op_e'(ALUControl);

    // Shared adder: SUB is A + ~B + 1, so the carry-out means "no borrow".
    always_comb begin
        src_b_eff = ALUControl[0] ? ~SrcB : SrcB;
        sum       = {1'b0, SrcA} + {1'b0, src_b_eff} + {{WIDTH{1'b0}}, ALUControl[0]};
    end

    // Result select; every opcode is fully decoded so nothing goes X.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves the output unassigned (no latch).
        ALUResult = '0;
        unique case (op)
            OP_ADD:  ALUResult = sum[MSB:0];
            OP_SUB:  ALUResult = sum[MSB:0];
            OP_AND:  ALUResult = SrcA & SrcB;
            OP_ORR:  ALUResult = SrcA | SrcB;
            default: ALUResult = '0;
        endcase
    end

    // Condition flags; C and V are only meaningful for the arithmetic ops.
    always_comb begin
        flag_n   = ALUResult[MSB];
        flag_z   = (ALUResult == '0);
        flag_c   = ~ALUControl[1] & sum[WIDTH];
        flag_v   = ~ALUControl[1]
                 & ~(ALUControl[0] ^ SrcA[MSB] ^ SrcB[MSB])
                 & (SrcA[MSB] ^ sum[MSB]);
        ALUFlags = {flag_n, flag_z, flag_c, flag_v};
    end

    // Next value of the flags register: load on FlagWrite, otherwise hold.
    always_comb begin
        flags_d = FlagWrite ? ALUFlags : flags_q;
    end

    // Flags register with asynchronous clear; reset overrides FlagWrite.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking (<=) so all flops update together at the edge.
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign FlagsQ = flags_q;

`ifdef ALU_ONE_OVF_STICKY_EN
    logic ovf_sticky_d;
    logic ovf_sticky_q;

    // Sticky overflow sets on a written overflow and stays set until reset.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q | (FlagWrite & ALUFlags[0]);
    end

    // Sticky overflow register; reset wins over a same-cycle set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign OvfSticky = ovf_sticky_q;
`else
    assign OvfSticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_one.sv
// ----------------------------------------------------------------------------
// tb_alu_one: directed self-checking bench for alu_one (WIDTH = 32).
// Inputs change on the falling edge; outputs are sampled 1 time unit later
// (combinational) or 1 time unit after the rising edge (registered).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_one;

    localparam int WIDTH = 32;

`ifdef ALU_ONE_OVF_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [1:0]       ALUControl;
    logic             FlagWrite;
    logic [WIDTH-1:0] ALUResult;
    logic [3:0]       ALUFlags;
    logic [3:0]       FlagsQ;
    logic             OvfSticky;

    int checks = 0;
    int errors = 0;

    alu_one #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .FlagWrite  (FlagWrite),
        .ALUResult  (ALUResult),
        .ALUFlags   (ALUFlags),
        .FlagsQ     (FlagsQ),
        .OvfSticky  (OvfSticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one operation, then check the combinational result and flags.
    task automatic alu_vec(input string tag, input logic [1:0] ctrl,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] exp_res, input logic [3:0] exp_flags);
        ALUControl = ctrl;
        SrcA       = a;
        SrcB       = b;
        #1;
        check({tag, " result"}, ALUResult, exp_res);
        check({tag, " flags"}, {28'd0, ALUFlags}, {28'd0, exp_flags});
    endtask

    initial begin
        reset      = 1'b1;
        FlagWrite  = 1'b0;
        ALUControl = 2'b00;
        SrcA       = '0;
        SrcB       = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset FlagsQ", {28'd0, FlagsQ}, 32'd0);
        check("reset OvfSticky", {31'd0, OvfSticky}, 32'd0);
        reset = 1'b0;

        // Combinational vectors
        alu_vec("SUB 2-1",   2'b01, 32'h2,        32'h1,        32'h00000001, 4'b0010);
        alu_vec("SUB 5-3",   2'b01, 32'h5,        32'h3,        32'h00000002, 4'b0010);
        alu_vec("SUB 3-5",   2'b01, 32'h3,        32'h5,        32'hFFFFFFFE, 4'b1000);
        alu_vec("ORR 3|5",   2'b11, 32'h3,        32'h5,        32'h00000007, 4'b0000);
        alu_vec("AND 3&5",   2'b10, 32'h3,        32'h5,        32'h00000001, 4'b0000);
        alu_vec("ADD ovf",   2'b00, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1001);
        alu_vec("ADD wrap",  2'b00, 32'hFFFFFFFF, 32'h1,        32'h00000000, 4'b0110);
        alu_vec("SUB 7-7",   2'b01, 32'h7,        32'h7,        32'h00000000, 4'b0110);
        alu_vec("SUB 0-1",   2'b01, 32'h0,        32'h1,        32'hFFFFFFFF, 4'b1000);
        alu_vec("SUB minov", 2'b01, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0011);
        alu_vec("ADD negov", 2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111);
        alu_vec("AND zero",  2'b10, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0100);
        alu_vec("ORR neg",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000);
        alu_vec("ADD 12+30", 2'b00, 32'd12,       32'd30,       32'd42,       4'b0000);

        // FlagWrite=0 keeps FlagsQ at its reset value
        @(posedge clk); #1;
        check("hold after reset", {28'd0, FlagsQ}, 32'd0);

        // Capture SUB 3-5
        @(negedge clk);
        FlagWrite = 1'b1;
        alu_vec("cap SUB 3-5", 2'b01, 32'h3, 32'h5, 32'hFFFFFFFE, 4'b1000);
        @(posedge clk); #1;
        check("capture FlagsQ", {28'd0, FlagsQ}, {28'd0, 4'b1000});

        // Hold while different flags are on the bus
        @(negedge clk);
        FlagWrite = 1'b0;
        alu_vec("hold ADD wrap", 2'b00, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0110);
        @(posedge clk); #1;
        check("hold FlagsQ", {28'd0, FlagsQ}, {28'd0, 4'b1000});

        // Mid-cycle asynchronous reset, no clock edge involved
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("async reset FlagsQ", {28'd0, FlagsQ}, 32'd0);

        // Reset overrides FlagWrite across a rising edge
        FlagWrite = 1'b1;
        alu_vec("rst SUB 3-5", 2'b01, 32'h3, 32'h5, 32'hFFFFFFFE, 4'b1000);
        @(posedge clk); #1;
        check("reset beats FlagWrite", {28'd0, FlagsQ}, 32'd0);

        // First capture after reset deasserts
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("first capture", {28'd0, FlagsQ}, {28'd0, 4'b1000});
        check("no sticky yet", {31'd0, OvfSticky}, 32'd0);

        // Sticky overflow
        @(negedge clk);
        alu_vec("stk ADD ovf", 2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001);
        @(posedge clk); #1;
        check("FlagsQ ovf", {28'd0, FlagsQ}, {28'd0, 4'b1001});
        check("sticky set", {31'd0, OvfSticky}, {31'd0, STICKY_EN});

        @(negedge clk);
        alu_vec("stk ADD 1+1", 2'b00, 32'h1, 32'h1, 32'h2, 4'b0000);
        @(posedge clk); #1;
        check("FlagsQ 1+1", {28'd0, FlagsQ}, 32'd0);
        check("sticky holds", {31'd0, OvfSticky}, {31'd0, STICKY_EN});

        @(negedge clk);
        FlagWrite = 1'b0;
        reset     = 1'b1;
        #1;
        check("sticky reset", {31'd0, OvfSticky}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("sticky stays clear", {31'd0, OvfSticky}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
